// File: rtl/usb_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_arb_pkg
// Shared types and constants for the usb_tx packet arbiter.
//   usb_tx_arb_state_t : arbiter FSM state encoding
//   USB_MIN_IPG_CLK48  : default inter-packet gap in clk48 cycles
//   ptr_w()            : width of a source index, never less than 1 bit so that
//                        a single-source build still has a legal pointer
// -----------------------------------------------------------------------------
package usb_tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_DRAIN,
    ARB_GAP
  } usb_tx_arb_state_t;

  localparam int USB_MIN_IPG_CLK48 = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// usb_tx_arbiter_if
// Byte-stream link between the arbiter and the usb_tx serializer.
//   txReqSendPacket_o  arbiter -> usb_tx  packet request
//   txIsLastByte_o     arbiter -> usb_tx  current byte is the last one
//   txDataValid_o      arbiter -> usb_tx  txData_o holds a valid byte
//   txData_o[7:0]      arbiter -> usb_tx  byte
//   txAcceptNewData_i  usb_tx -> arbiter  serializer takes the current byte
//   sending_i          usb_tx -> arbiter  serializer is driving the line
// master = arbiter side, slave = usb_tx side.
// -----------------------------------------------------------------------------
interface usb_tx_arbiter_if;

  logic       txReqSendPacket_o;
  logic       txIsLastByte_o;
  logic       txDataValid_o;
  logic [7:0] txData_o;
  logic       txAcceptNewData_i;
  logic       sending_i;

  modport master (
    output txReqSendPacket_o,
    output txIsLastByte_o,
    output txDataValid_o,
    output txData_o,
    input  txAcceptNewData_i,
    input  sending_i
  );

  modport slave (
    input  txReqSendPacket_o,
    input  txIsLastByte_o,
    input  txDataValid_o,
    input  txData_o,
    output txAcceptNewData_i,
    output sending_i
  );

endinterface

// File: rtl/usb_tx_arbiter_picker.sv
// -----------------------------------------------------------------------------
// usb_rr_picker
// Purely combinational winner selection. Searches the request vector starting
// at index ptr and wrapping around; the first set bit wins. With ptr tied to 0
// this is plain fixed priority (lowest index wins).
//   req[NUM_SRC-1:0]    request vector
//   ptr[PTR_W-1:0]      search start index
//   winner[NUM_SRC-1:0] one-hot winner, all zero when no request
// -----------------------------------------------------------------------------
module usb_rr_picker #(
  parameter int NUM_SRC = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] winner
);

  logic found;
  int   idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Modulo also folds a pointer that exceeds NUM_SRC-1 back into range.
      idx = (int'(ptr) + i) % NUM_SRC;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usb_tx_arbiter
// Packet-level arbiter sharing one usb_tx byte stream between NUM_SRC sources.
// One source is granted per packet; its byte stream is forwarded unchanged.
// The grant is held until the last byte is accepted and the serializer has
// finished driving the line, then a gap of GAP_CYCLES is enforced before the
// next arbitration.
//
// Parameters: NUM_SRC (>=1), ROUND_ROBIN (0 fixed priority, 1 round-robin),
//             GAP_CYCLES (>=1)
// Ports:
//   clk48_i, rst_i             clock and synchronous active-high reset
//   srcReq_i[NUM_SRC]          per-source packet request (level)
//   srcGrant_o[NUM_SRC]        one-hot grant, registered
//   srcAcceptNewData_o         accept routed to the granted source only
//   srcIsLastByte_i, srcDataValid_i, srcData_i[8*NUM_SRC]  source byte streams
//   tx                         usb_tx link (master side)
//   busy_o                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module usb_tx_arbiter
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int ROUND_ROBIN = 0,
  parameter int GAP_CYCLES  = USB_MIN_IPG_CLK48
) (
  input  logic                 clk48_i,
  input  logic                 rst_i,
  input  logic [NUM_SRC-1:0]   srcReq_i,
  output logic [NUM_SRC-1:0]   srcGrant_o,
  output logic [NUM_SRC-1:0]   srcAcceptNewData_o,
  input  logic [NUM_SRC-1:0]   srcIsLastByte_i,
  input  logic [NUM_SRC-1:0]   srcDataValid_i,
  input  logic [8*NUM_SRC-1:0] srcData_i,
  usb_tx_arbiter_if.master     tx,
  output logic                 busy_o
);

  localparam int PTR_W = ptr_w(NUM_SRC);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  usb_tx_arb_state_t  state_reg;
  logic [NUM_SRC-1:0] grant_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic               saw_sending_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               tx_req_reg;
  logic               busy_reg;

  logic [NUM_SRC-1:0] pick;
  logic [PTR_W-1:0]   pick_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  int                 win_idx;

  logic               streaming;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [7:0]         data_terms [NUM_SRC];
  logic               last_hs;

  // ---------------------------------------------------------------------------
  // Winner selection. Fixed priority is the same search anchored at index 0.
  // ---------------------------------------------------------------------------
  assign pick_ptr = (ROUND_ROBIN != 0) ? rr_ptr_reg : '0;

  usb_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (srcReq_i),
    .ptr    (pick_ptr),
    .winner (pick)
  );

  always_comb begin
    win_idx = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick[i]) begin
        win_idx = i;
      end
    end
    rr_ptr_next = PTR_W'((win_idx + 1) % NUM_SRC);
  end

  // ---------------------------------------------------------------------------
  // Data path: AND-OR mux driven by the registered one-hot grant, so the byte
  // stream passes through with no added latency.
  // ---------------------------------------------------------------------------
  assign streaming = (state_reg == ARB_STREAM);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign data_terms[gi]         = grant_reg[gi] ? srcData_i[8*gi +: 8] : 8'h00;
    assign srcAcceptNewData_o[gi] = streaming && grant_reg[gi] && tx.txAcceptNewData_i;
  end

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data = sel_data | data_terms[i];
    end
  end

  assign sel_valid = |(grant_reg & srcDataValid_i);
  assign sel_last  = |(grant_reg & srcIsLastByte_i);

  assign tx.txReqSendPacket_o = tx_req_reg;
  assign tx.txDataValid_o     = streaming && sel_valid;
  assign tx.txIsLastByte_o    = streaming && sel_last;
  assign tx.txData_o          = streaming ? sel_data : 8'h00;

  // Accept alone is not a handshake; valid and last must coincide with it.
  assign last_hs = streaming && tx.txAcceptNewData_i && sel_valid && sel_last;

  assign srcGrant_o = grant_reg;
  assign busy_o     = busy_reg;

  // ---------------------------------------------------------------------------
  // Arbiter FSM with registered grant / request / busy outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk48_i) begin
    if (rst_i) begin
      state_reg       <= ARB_IDLE;
      grant_reg       <= '0;
      rr_ptr_reg      <= '0;
      saw_sending_reg <= 1'b0;
      gap_cnt_reg     <= '0;
      tx_req_reg      <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (|srcReq_i) begin
            grant_reg  <= pick;
            tx_req_reg <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= ARB_STREAM;
            if (ROUND_ROBIN != 0) begin
              rr_ptr_reg <= rr_ptr_next;
            end
          end
        end

        ARB_STREAM: begin
          // Dropping the request mid-packet is ignored; only the last-byte
          // handshake ends the packet.
          if (last_hs) begin
            tx_req_reg      <= 1'b0;
            // A sending_i level seen in the handshake cycle must not count:
            // the drain waits for a fresh rise and fall.
            saw_sending_reg <= 1'b0;
            state_reg       <= ARB_DRAIN;
          end
        end

        ARB_DRAIN: begin
          if (saw_sending_reg && !tx.sending_i) begin
            grant_reg       <= '0;
            saw_sending_reg <= 1'b0;
            gap_cnt_reg     <= GAP_LOAD;
            state_reg       <= ARB_GAP;
          end else if (tx.sending_i) begin
            saw_sending_reg <= 1'b1;
          end
        end

        ARB_GAP: begin
          if (gap_cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= ARB_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end

        default: begin
          grant_reg  <= '0;
          tx_req_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_arbiter
// Directed bench for usb_tx_arbiter. Three instances share clock and reset:
//   dut_a : NUM_SRC=2, fixed priority, GAP_CYCLES=8
//   dut_b : NUM_SRC=3, round-robin,    GAP_CYCLES=4
//   dut_c : NUM_SRC=1, fixed priority, GAP_CYCLES=1
// Inputs are driven at the falling edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_usb_tx_arbiter;

  localparam int GAP_A = 8;
  localparam int GAP_B = 4;
  localparam int GAP_C = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // dut_a
  logic [1:0]  req_a, grant_a, acc_a, last_a, valid_a;
  logic [15:0] data_a;
  logic        busy_a;
  usb_tx_arbiter_if txa ();

  usb_tx_arbiter #(.NUM_SRC(2), .ROUND_ROBIN(0), .GAP_CYCLES(GAP_A)) dut_a (
    .clk48_i(clk), .rst_i(rst), .srcReq_i(req_a), .srcGrant_o(grant_a),
    .srcAcceptNewData_o(acc_a), .srcIsLastByte_i(last_a),
    .srcDataValid_i(valid_a), .srcData_i(data_a), .tx(txa), .busy_o(busy_a)
  );

  // dut_b
  logic [2:0]  req_b, grant_b, acc_b, last_b, valid_b;
  logic [23:0] data_b;
  logic        busy_b;
  usb_tx_arbiter_if txb ();

  usb_tx_arbiter #(.NUM_SRC(3), .ROUND_ROBIN(1), .GAP_CYCLES(GAP_B)) dut_b (
    .clk48_i(clk), .rst_i(rst), .srcReq_i(req_b), .srcGrant_o(grant_b),
    .srcAcceptNewData_o(acc_b), .srcIsLastByte_i(last_b),
    .srcDataValid_i(valid_b), .srcData_i(data_b), .tx(txb), .busy_o(busy_b)
  );

  // dut_c
  logic [0:0]  req_c, grant_c, acc_c, last_c, valid_c;
  logic [7:0]  data_c;
  logic        busy_c;
  usb_tx_arbiter_if txc ();

  usb_tx_arbiter #(.NUM_SRC(1), .ROUND_ROBIN(0), .GAP_CYCLES(GAP_C)) dut_c (
    .clk48_i(clk), .rst_i(rst), .srcReq_i(req_c), .srcGrant_o(grant_c),
    .srcAcceptNewData_o(acc_c), .srcIsLastByte_i(last_c),
    .srcDataValid_i(valid_c), .srcData_i(data_c), .tx(txc), .busy_o(busy_c)
  );

  // Finish a dut_a packet that is already in DRAIN: one sending_i pulse, then
  // wait out the gap so the arbiter is back in IDLE.
  task automatic drain_a();
    @(negedge clk);
    req_a = '0; valid_a = '0; last_a = '0; data_a = '0;
    txa.txAcceptNewData_i = 1'b0; txa.sending_i = 1'b1;
    @(negedge clk);
    txa.sending_i = 1'b0;
    repeat (GAP_A + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = 2'b11; valid_a = 2'b11; last_a = 2'b11; data_a = 16'hFFFF;
    txa.txAcceptNewData_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant_a); end
    total++; if (txa.txReqSendPacket_o !== 1'b0) begin bad++; $display("FAIL reset_txreq: got %b want 0", txa.txReqSendPacket_o); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    total++; if (txa.txDataValid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", txa.txDataValid_o); end
    total++; if (txa.txData_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", txa.txData_o); end
    total++; if (txa.txIsLastByte_o !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", txa.txIsLastByte_o); end
    total++; if (acc_a !== 2'b00) begin bad++; $display("FAIL reset_accept: got %b want 00", acc_a); end
    total++; if (grant_b !== 3'b000 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_b: got grant=%b busy=%b want 000/0", grant_b, busy_b); end
    @(negedge clk);
    rst = 1'b0;
    req_a = '0; valid_a = '0; last_a = '0; data_a = '0;
    txa.txAcceptNewData_i = 1'b0;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_single_packet();
    logic [7:0] bytes [3];
    bytes[0] = 8'hC3; bytes[1] = 8'h11; bytes[2] = 8'h22;
    @(negedge clk);
    req_a = 2'b10;
    #1;
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL single_pregrant: got %b want 00", grant_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_a = 2'b10; data_a = {bytes[i], 8'h00};
      last_a = (i == 2) ? 2'b10 : 2'b00;
      txa.txAcceptNewData_i = 1'b1;
      #1;
      total++; if (txa.txData_o !== bytes[i]) begin bad++; $display("FAIL single_data%0d: got %h want %h", i, txa.txData_o, bytes[i]); end
      total++; if (grant_a !== 2'b10) begin bad++; $display("FAIL single_grant%0d: got %b want 10", i, grant_a); end
      if (i == 0) begin
        total++; if (txa.txReqSendPacket_o !== 1'b1 || busy_a !== 1'b1) begin bad++; $display("FAIL single_req: got req=%b busy=%b want 1/1", txa.txReqSendPacket_o, busy_a); end
        total++; if (acc_a !== 2'b10) begin bad++; $display("FAIL single_accept: got %b want 10", acc_a); end
      end
      if (i == 2) begin
        total++; if (txa.txIsLastByte_o !== 1'b1) begin bad++; $display("FAIL single_last: got %b want 1", txa.txIsLastByte_o); end
      end
      $display("single: byte %0d data=%h", i, txa.txData_o);
    end
    @(negedge clk);
    valid_a = '0; last_a = '0; data_a = '0; req_a = '0;
    txa.txAcceptNewData_i = 1'b0; txa.sending_i = 1'b1;
    #1;
    total++; if (txa.txReqSendPacket_o !== 1'b0 || txa.txDataValid_o !== 1'b0) begin bad++; $display("FAIL single_drain_tx: got req=%b valid=%b want 0/0", txa.txReqSendPacket_o, txa.txDataValid_o); end
    total++; if (grant_a !== 2'b10) begin bad++; $display("FAIL single_drain_grant: got %b want 10", grant_a); end
    @(negedge clk);
    txa.sending_i = 1'b0;
    #1;
    total++; if (grant_a !== 2'b10) begin bad++; $display("FAIL single_fall_grant: got %b want 10", grant_a); end
    // busy stays high for GAP_A cycles after the cycle in which sending_i is
    // first low, and is low in cycle GAP_A+1.
    for (int j = 1; j <= GAP_A + 1; j++) begin
      @(negedge clk);
      #1;
      total++; if (busy_a !== (j <= GAP_A)) begin bad++; $display("FAIL single_gap_busy%0d: got %b want %b", j, busy_a, (j <= GAP_A)); end
      total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL single_gap_grant%0d: got %b want 00", j, grant_a); end
    end
    $display("single: packet src=1 complete");
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    req_a = 2'b11;
    @(negedge clk);
    valid_a = 2'b11; last_a = 2'b11; data_a = 16'h66A5;
    txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL prio_first: got %b want 01", grant_a); end
    total++; if (txa.txData_o !== 8'hA5) begin bad++; $display("FAIL prio_data0: got %h want a5", txa.txData_o); end
    @(negedge clk);
    valid_a = '0; last_a = '0; req_a = 2'b10;
    txa.txAcceptNewData_i = 1'b0; txa.sending_i = 1'b1;
    @(negedge clk);
    txa.sending_i = 1'b0;
    #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL prio_hold: got %b want 01", grant_a); end
    // The edge after this cycle registers the fall; the next grant appears
    // GAP_A+1 cycles after that edge, i.e. in cycle GAP_A+2 counted from here.
    for (int j = 1; j <= GAP_A + 2; j++) begin
      @(negedge clk);
      #1;
      total++; if (grant_a !== ((j == GAP_A + 2) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL prio_turn%0d: got %b want %b", j, grant_a, ((j == GAP_A + 2) ? 2'b10 : 2'b00)); end
    end
    valid_a = 2'b10; last_a = 2'b10; data_a = 16'h7700;
    txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (txa.txData_o !== 8'h77) begin bad++; $display("FAIL prio_data1: got %h want 77", txa.txData_o); end
    $display("prio: src0 then src1 granted");
    drain_a();
  endtask

  task automatic test_round_robin();
    logic       found;
    logic [2:0] exp_g;
    req_b = 3'b111; valid_b = 3'b111; last_b = 3'b111;
    data_b = {8'h12, 8'h11, 8'h10};
    for (int p = 0; p < 6; p++) begin
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        @(negedge clk);
        #1;
        if (grant_b !== 3'b000) found = 1'b1;
      end
      exp_g = 3'b001 << (p % 3);
      total++; if (!found) begin bad++; $display("FAIL rr_timeout%0d: got no grant want %b", p, exp_g); end
      total++; if (grant_b !== exp_g) begin bad++; $display("FAIL rr_order%0d: got %b want %b", p, grant_b, exp_g); end
      txb.txAcceptNewData_i = 1'b1;
      #1;
      total++; if (txb.txData_o !== (8'h10 + 8'(p % 3))) begin bad++; $display("FAIL rr_data%0d: got %h want %h", p, txb.txData_o, 8'h10 + 8'(p % 3)); end
      $display("rr: packet %0d grant=%b data=%h", p, grant_b, txb.txData_o);
      @(negedge clk);
      txb.txAcceptNewData_i = 1'b0; txb.sending_i = 1'b1;
      @(negedge clk);
      txb.sending_i = 1'b0;
    end
    req_b = '0; valid_b = '0; last_b = '0;
    repeat (GAP_B + 2) @(negedge clk);
  endtask

  task automatic test_withdrawal();
    @(negedge clk);
    req_a = 2'b01;
    @(negedge clk);
    valid_a = 2'b01; last_a = 2'b00; data_a = 16'h0001;
    txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (txa.txData_o !== 8'h01) begin bad++; $display("FAIL wd_data0: got %h want 01", txa.txData_o); end
    @(negedge clk);
    req_a = 2'b00; data_a = 16'h0002;
    #1;
    total++; if (grant_a !== 2'b01 || txa.txReqSendPacket_o !== 1'b1) begin bad++; $display("FAIL wd_hold: got grant=%b req=%b want 01/1", grant_a, txa.txReqSendPacket_o); end
    @(negedge clk);
    txa.txAcceptNewData_i = 1'b0;
    #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL wd_pause: got %b want 01", grant_a); end
    @(negedge clk);
    data_a = 16'h0003; last_a = 2'b01; txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (txa.txIsLastByte_o !== 1'b1 || txa.txData_o !== 8'h03) begin bad++; $display("FAIL wd_last: got last=%b data=%h want 1/03", txa.txIsLastByte_o, txa.txData_o); end
    @(negedge clk);
    valid_a = '0; last_a = '0; txa.txAcceptNewData_i = 1'b0;
    #1;
    total++; if (txa.txReqSendPacket_o !== 1'b0 || grant_a !== 2'b01) begin bad++; $display("FAIL wd_drain: got req=%b grant=%b want 0/01", txa.txReqSendPacket_o, grant_a); end
    $display("withdraw: packet src=0 completed after request drop");
    drain_a();
  endtask

  task automatic test_accept_without_valid();
    @(negedge clk);
    req_a = 2'b10;
    @(negedge clk);
    valid_a = 2'b00; last_a = 2'b10; data_a = 16'h5A00;
    txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (acc_a !== 2'b10) begin bad++; $display("FAIL nv_fwd: got %b want 10", acc_a); end
    total++; if (txa.txDataValid_o !== 1'b0) begin bad++; $display("FAIL nv_valid: got %b want 0", txa.txDataValid_o); end
    @(negedge clk);
    txa.txAcceptNewData_i = 1'b0;
    #1;
    total++; if (txa.txReqSendPacket_o !== 1'b1 || busy_a !== 1'b1) begin bad++; $display("FAIL nv_state: got req=%b busy=%b want 1/1", txa.txReqSendPacket_o, busy_a); end
    @(negedge clk);
    valid_a = 2'b10; txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (txa.txData_o !== 8'h5A || txa.txDataValid_o !== 1'b1) begin bad++; $display("FAIL nv_byte: got data=%h valid=%b want 5a/1", txa.txData_o, txa.txDataValid_o); end
    @(negedge clk);
    valid_a = '0; last_a = '0; txa.txAcceptNewData_i = 1'b0;
    #1;
    total++; if (txa.txReqSendPacket_o !== 1'b0) begin bad++; $display("FAIL nv_end: got %b want 0", txa.txReqSendPacket_o); end
    $display("noval: accept without valid ignored");
    drain_a();
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    req_a = 2'b01;
    @(negedge clk);
    valid_a = 2'b01; last_a = 2'b00; data_a = 16'h0031;
    txa.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (txa.txData_o !== 8'h31) begin bad++; $display("FAIL rms_b1: got %h want 31", txa.txData_o); end
    @(negedge clk);
    data_a = 16'h0032;
    #1;
    total++; if (txa.txData_o !== 8'h32) begin bad++; $display("FAIL rms_b2: got %h want 32", txa.txData_o); end
    @(negedge clk);
    rst = 1'b1; data_a = 16'h0033;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (txa.txReqSendPacket_o !== 1'b0 || grant_a !== 2'b00 || busy_a !== 1'b0) begin bad++; $display("FAIL rms_reset: got req=%b grant=%b busy=%b want 0/00/0", txa.txReqSendPacket_o, grant_a, busy_a); end
    total++; if (txa.txDataValid_o !== 1'b0) begin bad++; $display("FAIL rms_valid: got %b want 0", txa.txDataValid_o); end
    @(negedge clk);
    #1;
    total++; if (grant_a !== 2'b01 || txa.txReqSendPacket_o !== 1'b1) begin bad++; $display("FAIL rms_regrant: got grant=%b req=%b want 01/1", grant_a, txa.txReqSendPacket_o); end
    last_a = 2'b01;
    #1;
    total++; if (txa.txIsLastByte_o !== 1'b1) begin bad++; $display("FAIL rms_last: got %b want 1", txa.txIsLastByte_o); end
    $display("rstmid: packet restarted after reset");
    drain_a();
  endtask

  task automatic test_single_source();
    @(negedge clk);
    req_c = 1'b1;
    @(negedge clk);
    valid_c = 1'b1; last_c = 1'b1; data_c = 8'h9E;
    txc.txAcceptNewData_i = 1'b1;
    #1;
    total++; if (grant_c !== 1'b1 || txc.txData_o !== 8'h9E) begin bad++; $display("FAIL one_pkt: got grant=%b data=%h want 1/9e", grant_c, txc.txData_o); end
    @(negedge clk);
    req_c = 1'b0; valid_c = 1'b0; last_c = 1'b0;
    txc.txAcceptNewData_i = 1'b0; txc.sending_i = 1'b1;
    #1;
    total++; if (grant_c !== 1'b1 || txc.txReqSendPacket_o !== 1'b0) begin bad++; $display("FAIL one_drain: got grant=%b req=%b want 1/0", grant_c, txc.txReqSendPacket_o); end
    @(negedge clk);
    txc.sending_i = 1'b0;
    @(negedge clk);
    #1;
    total++; if (grant_c !== 1'b0 || busy_c !== 1'b1) begin bad++; $display("FAIL one_gap: got grant=%b busy=%b want 0/1", grant_c, busy_c); end
    @(negedge clk);
    #1;
    total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL one_idle: got %b want 0", busy_c); end
    $display("one: single-source packet complete");
  endtask

  initial begin
    rst = 1'b1;
    req_a = '0; valid_a = '0; last_a = '0; data_a = '0;
    req_b = '0; valid_b = '0; last_b = '0; data_b = '0;
    req_c = '0; valid_c = '0; last_c = '0; data_c = '0;
    txa.txAcceptNewData_i = 1'b0; txa.sending_i = 1'b0;
    txb.txAcceptNewData_i = 1'b0; txb.sending_i = 1'b0;
    txc.txAcceptNewData_i = 1'b0; txc.sending_i = 1'b0;
    test_reset();
    test_single_packet();
    test_fixed_priority();
    test_round_robin();
    test_withdrawal();
    test_accept_without_valid();
    test_reset_mid_stream();
    test_single_source();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
